sd_data_rx: RTL and testbench
=============================

Name: sd_data_rx

Overview:
- Parametrised SD DAT-line block receiver; next generation of the single-width data path.
- Samples DAT[3:0] on sd_clk rising-edge strobes in the ex_clk domain.
- Supports 1-bit and 4-bit bus modes and a programmable block length; checks per-line CRC16 and the end bit.
- Delivers bytes to the FSM/UART side through an internal FIFO with a valid/ready handshake.

Parameters:
- MAX_BLOCK_BYTES, 512, largest block_len accepted; sets counter width clog2(MAX_BLOCK_BYTES+1).
- FIFO_DEPTH, 8, byte FIFO entries; must be a power of two, at least 2.
- TIMEOUT_SAMPLES, 65535, sd_clk samples allowed in WAIT_START before timeout.

Ports:
- ex_clk, input, 1, system clock; sole clock.
- ex_resetn, input, 1, asynchronous active-low reset.
- sd_clk_rise, input, 1, one-ex_clk strobe marking an sd_clk rising edge; DAT is sampled only when this is high.
- dat_in, input, 4, DAT[3:0] pin values.
- start, input, 1, one-cycle pulse that arms the receiver; ignored unless busy=0.
- wide_bus, input, 1, 1 selects 4-bit mode; latched on start.
- block_len, input, clog2(MAX_BLOCK_BYTES+1), bytes per block; latched on start.
- abort, input, 1, synchronous cancel.
- rd_data, output, 8, FIFO head byte.
- rd_valid, output, 1, FIFO not empty.
- rd_ready, input, 1, consumer pop.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at block end.
- crc_err, output, 1, sticky per block.
- end_err, output, 1, sticky per block.
- timeout, output, 1, sticky per block.
- overrun, output, 1, sticky per block.

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0; rd_data 0.
- Error flags clear on an accepted start.
- All DAT processing happens only on cycles with sd_clk_rise=1. Ready/valid pops act on any cycle.
- Active lines: DAT0 in 1-bit mode, DAT[3:0] in 4-bit mode.
- IDLE -> WAIT_START on start.
  - If the latched block_len is 0 or greater than MAX_BLOCK_BYTES, go directly to DONE. Set end_err only; no data is pushed.
- WAIT_START:
  - Start bit = all active lines 0 on one sample -> DATA.
  - Partial low (some active lines 0, not all) also sets end_err and goes to DATA.
  - Sample counter reaching TIMEOUT_SAMPLES -> set timeout, go to DONE.
- DATA:
  - Bits are MSB first.
  - 1-bit mode: 8 samples per byte.
  - 4-bit mode: 2 samples per byte; the first sample is the high nibble, and dat_in[3] carries the nibble MSB.
  - Each line's bit feeds its own CRC16 (poly 0x1021, init 0).
  - On completion of byte N (N = block_len-1) -> CRC.
- CRC:
  - 16 samples; each active line's bit is compared MSB first against that line's computed CRC.
  - Any mismatch sets crc_err.
  - -> END.
- END:
  - One sample; any active line 0 sets end_err.
  - -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done is high.
- FIFO:
  - A byte is pushed the cycle it completes.
  - If the FIFO is full with no simultaneous pop, the byte is dropped and overrun is set. Reception continues.
  - Push and pop in the same cycle on a full FIFO succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- abort: in any state -> IDLE the next cycle. Error flags are not altered, done is not pulsed, and FIFO contents are retained.
- start while busy=1 is ignored.
- Async reset mid-block returns to reset values immediately.

Optional Feature:
- SD_RX_WIDE_BUS_EN defined: 4-bit mode available as above, with four CRC16 instances.
- Not defined:
  - wide_bus is ignored and treated as 0.
  - Only the DAT0 CRC is instantiated.
  - dat_in[3:1] is unused.

Decomposition:
- Package sd_data_pkg holds:
  - state enum (IDLE, WAIT_START, DATA, CRC, END, DONE);
  - SD_CRC16_POLY = 16'h1021;
  - SD_CRC16_INIT = 16'h0000.
- Sub-module sd_crc16: serial CRC16 with ex_clk, ex_resetn, clear, enable, bit_in, crc_out. Instantiated one per line.
- The FIFO stays inline; it is too small to justify a separate module.

Test Plan:
- 1-bit mode, block_len=512, all data 0xFF, CRC 0x7FA1, end bit 1, rd_ready=1 -> 512 bytes of 0xFF, done pulse, all error flags 0.
- Same as above with CRC bit 0 flipped -> identical data, done, crc_err=1.
- 4-bit mode, block_len=4, bytes 0x12 0x34 0x56 0x78, per-line CRCs from the reference model -> output 0x12 0x34 0x56 0x78 in order, no errors. A single corrupted line-2 CRC bit -> crc_err=1.
- TIMEOUT_SAMPLES=16, DAT held 1 after start -> timeout=1 and done after 16 samples; FIFO empty.
- FIFO_DEPTH=8, rd_ready=0, block_len=10 -> 8 bytes held, overrun=1, done. Draining yields the first 8 bytes.
- abort during DATA after 3 bytes -> IDLE next cycle, no done pulse, 3 bytes readable. A following start on a valid block succeeds.

Source files
------------

// File: rtl/sd_data_pkg.sv
// Shared types and constants for the SD DAT-line receiver.
// Holds the receiver state encoding and the serial CRC16 step function.
package sd_data_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    DATA       = 3'd2,
    CRC        = 3'd3,
    END        = 3'd4,
    DONE       = 3'd5
  } sd_rx_state_t;

  localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
  localparam logic [15:0] SD_CRC16_INIT = 16'h0000;

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_next = {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1) for one DAT line, one bit per enabled cycle.
module sd_crc16 (
  input  logic        ex_clk,
  input  logic        ex_resetn,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc_out
);
  import sd_data_pkg::*;

  logic [15:0] r_crc;

  // CRC shift register; clear wins over enable
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_crc <= SD_CRC16_INIT;
    end else if (clear) begin
      r_crc <= SD_CRC16_INIT;
    end else if (enable) begin
      r_crc <= crc16_next(r_crc, bit_in);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/sd_data_rx.sv
// SD DAT-line block receiver with per-line CRC16 check and a byte FIFO.
// 4-bit bus mode is only available when SD_RX_WIDE_BUS_EN is defined.
module sd_data_rx #(
  parameter int  MAX_BLOCK_BYTES = 512,
  parameter int  FIFO_DEPTH      = 8,
  parameter int  TIMEOUT_SAMPLES = 65535,
  localparam int LEN_W           = $clog2(MAX_BLOCK_BYTES + 1)
) (
  input  logic             ex_clk,
  input  logic             ex_resetn,
  input  logic             sd_clk_rise,
  input  logic [3:0]       dat_in,
  input  logic             start,
  input  logic             wide_bus,
  input  logic [LEN_W-1:0] block_len,
  input  logic             abort,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             crc_err,
  output logic             end_err,
  output logic             timeout,
  output logic             overrun
);
  import sd_data_pkg::*;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
`ifdef SD_RX_WIDE_BUS_EN
  localparam int   N_LINES = 4;
  localparam logic WIDE_OK = 1'b1;
`else
  localparam int   N_LINES = 1;
  localparam logic WIDE_OK = 1'b0;
`endif

  sd_rx_state_t     r_state, w_state_nxt;
  logic             r_wide;
  logic [LEN_W-1:0] r_len, r_byte_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [3:0]       r_crc_idx;
  logic [TW-1:0]    r_to_cnt;
  logic             r_busy, r_done, r_crc_err, r_end_err, r_timeout, r_overrun;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic [3:0]       w_mask, w_act, w_crc_bits;
  logic [7:0]       w_shift_nxt;
  logic             w_byte_done, w_last_byte, w_crc_miss;
  logic             w_accept, w_push, w_crc_en, w_crc_clr, w_set_crc, w_set_end, w_set_to;
  logic             w_pop, w_full, w_wr_ok, w_ovf;
  logic [CW-1:0]    w_count_nxt;
  logic [15:0]      w_crc [4];

  assign w_mask      = r_wide ? 4'hF : 4'h1;
  assign w_act       = dat_in & w_mask;
  assign w_shift_nxt = r_wide ? {r_shift[3:0], dat_in} : {r_shift[6:0], dat_in[0]};
  assign w_byte_done = r_wide ? r_bit_cnt[0] : (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == r_len - LEN_W'(1));
  assign w_crc_miss  = |((dat_in ^ w_crc_bits) & w_mask);

  for (genvar k = 0; k < 4; k++) begin : g_line
    if (k < N_LINES) begin : g_crc
      sd_crc16 u_crc (
        .ex_clk    (ex_clk),
        .ex_resetn (ex_resetn),
        .clear     (w_crc_clr),
        .enable    (w_crc_en & w_mask[k]),
        .bit_in    (dat_in[k]),
        .crc_out   (w_crc[k])
      );
    end else begin : g_none
      assign w_crc[k] = SD_CRC16_INIT;
    end
  end

  // Received CRC is compared MSB first against each line's frozen CRC
  always_comb begin
    w_crc_bits = 4'h0;
    for (int k = 0; k < 4; k++) begin
      w_crc_bits[k] = w_crc[k][4'd15 - r_crc_idx];
    end
  end

  // State register
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-sample control; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_clr   = 1'b0;
    w_set_crc   = 1'b0;
    w_set_end   = 1'b0;
    w_set_to    = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_accept  = 1'b1;
            w_crc_clr = 1'b1;
            if ((block_len == LEN_W'(0)) || (block_len > LEN_W'(MAX_BLOCK_BYTES))) begin
              w_set_end   = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = WAIT_START;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT_START: begin
          if (!sd_clk_rise) begin
            w_state_nxt = WAIT_START;
          end else if (w_act == 4'h0) begin
            w_state_nxt = DATA;
          end else if (w_act != w_mask) begin
            w_set_end   = 1'b1;
            w_state_nxt = DATA;
          end else if (r_to_cnt == TW'(TIMEOUT_SAMPLES - 1)) begin
            w_set_to    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT_START;
          end
        end
        DATA: begin
          if (sd_clk_rise) begin
            w_crc_en    = 1'b1;
            w_push      = w_byte_done;
            w_state_nxt = (w_byte_done && w_last_byte) ? CRC : DATA;
          end else begin
            w_state_nxt = DATA;
          end
        end
        CRC: begin
          if (sd_clk_rise) begin
            w_set_crc   = w_crc_miss;
            w_state_nxt = (r_crc_idx == 4'd15) ? END : CRC;
          end else begin
            w_state_nxt = CRC;
          end
        end
        END: begin
          if (sd_clk_rise) begin
            w_set_end   = (w_act != w_mask);
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = END;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they line up with it
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done    <= (w_state_nxt == DONE);
      r_crc_err <= (r_crc_err & ~w_accept) | w_set_crc;
      r_end_err <= (r_end_err & ~w_accept) | w_set_end;
      r_timeout <= (r_timeout & ~w_accept) | w_set_to;
      r_overrun <= (r_overrun & ~w_accept) | w_ovf;
    end
  end

  // Block configuration, byte assembly and sample counters
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_wide     <= 1'b0;
      r_len      <= LEN_W'(0);
      r_byte_cnt <= LEN_W'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_crc_idx  <= 4'd0;
      r_to_cnt   <= TW'(0);
    end else if (w_accept) begin
      r_wide     <= wide_bus & WIDE_OK;
      r_len      <= block_len;
      r_byte_cnt <= LEN_W'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_crc_idx  <= 4'd0;
      r_to_cnt   <= TW'(0);
    end else if (sd_clk_rise) begin
      if (r_state == WAIT_START) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (r_state == DATA) begin
        r_shift <= w_shift_nxt;
        if (w_byte_done) begin
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= r_byte_cnt + LEN_W'(1);
        end else begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
      end
      if (r_state == CRC) begin
        r_crc_idx <= r_crc_idx + 4'd1;
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign w_pop   = r_valid & rd_ready;
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_wr_ok = w_push & (~w_full | w_pop);
  assign w_ovf   = w_push & w_full & ~w_pop;

  // FIFO occupancy update
  always_comb begin
    case ({w_wr_ok, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr] <= w_shift_nxt;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != CW'(0));
    end
  end

  assign rd_data  = r_mem[r_rd_ptr];
  assign rd_valid = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign crc_err  = r_crc_err;
  assign end_err  = r_end_err;
  assign timeout  = r_timeout;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_sd_data_rx.sv
// Directed self-checking bench for sd_data_rx (1-bit, 4-bit when SD_RX_WIDE_BUS_EN,
// timeout, overrun, abort and invalid block length).
module tb_sd_data_rx;

  logic       ex_clk      = 1'b0;
  logic       ex_resetn   = 1'b0;
  logic       sd_clk_rise = 1'b0;
  logic [3:0] dat_in      = 4'hF;
  logic       start       = 1'b0;
  logic       wide_bus    = 1'b0;
  logic [9:0] block_len   = 10'd0;
  logic       abort       = 1'b0;
  logic       rd_ready    = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, done, crc_err, end_err, timeout, overrun;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          done_seen = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  tx_bytes[$];
  logic [15:0] tx_crc[4];
  int          base, dbase;

  always #5 ex_clk = ~ex_clk;

  sd_data_rx #(
    .MAX_BLOCK_BYTES (512),
    .FIFO_DEPTH      (8),
    .TIMEOUT_SAMPLES (16)
  ) dut (
    .ex_clk      (ex_clk),
    .ex_resetn   (ex_resetn),
    .sd_clk_rise (sd_clk_rise),
    .dat_in      (dat_in),
    .start       (start),
    .wide_bus    (wide_bus),
    .block_len   (block_len),
    .abort       (abort),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err),
    .end_err     (end_err),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  // Consumer and done-pulse monitor, sampled mid-cycle
  always @(negedge ex_clk) begin
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
    if (done) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ex_clk);
    #2;
  endtask

  task automatic sd_sample(input logic [3:0] d);
    @(posedge ex_clk); #2;
    dat_in = d;
    sd_clk_rise = 1'b1;
    @(posedge ex_clk); #2;
    sd_clk_rise = 1'b0;
  endtask

  task automatic do_start(input logic w, input int len);
    @(posedge ex_clk); #2;
    wide_bus  = w;
    block_len = 10'(len);
    start     = 1'b1;
    @(posedge ex_clk); #2;
    start = 1'b0;
    for (int k = 0; k < 4; k++) tx_crc[k] = 16'h0000;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic begin_block(input logic w);
    sd_sample(4'hF);
    sd_sample(4'hF);
    sd_sample(w ? 4'h0 : 4'hE);
  endtask

  task automatic send_byte(input logic w, input logic [7:0] b);
    logic [3:0] nib;
    if (w) begin
      for (int h = 1; h >= 0; h--) begin
        nib = (h == 1) ? b[7:4] : b[3:0];
        for (int k = 0; k < 4; k++) tx_crc[k] = crc_step(tx_crc[k], nib[k]);
        sd_sample(nib);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        tx_crc[0] = crc_step(tx_crc[0], b[i]);
        sd_sample({3'b111, b[i]});
      end
    end
  endtask

  task automatic send_crc_end(input logic w);
    for (int i = 15; i >= 0; i--) begin
      if (w) sd_sample({tx_crc[3][i], tx_crc[2][i], tx_crc[1][i], tx_crc[0][i]});
      else   sd_sample({3'b111, tx_crc[0][i]});
    end
    sd_sample(4'hF);
  endtask

  task automatic check_bytes(input string tag, input int from, input int n);
    int nbad = 0;
    check({tag, "_count"}, got_q.size() - from, n);
    for (int i = 0; i < n; i++) begin
      if ((got_q.size() <= from + i) || (got_q[from + i] !== tx_bytes[i])) nbad++;
    end
    check({tag, "_data"}, nbad, 0);
  endtask

  task automatic mark();
    base  = got_q.size();
    dbase = done_seen;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge ex_clk);
    check("rst_outs", {busy, done, rd_valid, crc_err, end_err, timeout, overrun}, 7'b0);
    check("rst_rd_data", rd_data, 8'h00);
    @(posedge ex_clk); #2;
    ex_resetn = 1'b1;
    rd_ready  = 1'b1;

    // 1-bit, 512 x 0xFF, good CRC 0x7FA1
    tx_bytes.delete();
    for (int i = 0; i < 512; i++) tx_bytes.push_back(8'hFF);
    mark();
    do_start(1'b0, 512);
    begin_block(1'b0);
    @(negedge ex_clk);
    check("t1_busy_active", busy, 1'b1);
    for (int i = 0; i < 512; i++) send_byte(1'b0, 8'hFF);
    tx_crc[0] = 16'h7FA1;
    send_crc_end(1'b0);
    tick(6);
    @(negedge ex_clk);
    check("t1_done", done_seen - dbase, 1);
    check_bytes("t1", base, 512);
    check("t1_flags", {crc_err, end_err, timeout, overrun}, 4'b0000);
    check("t1_busy_idle", busy, 1'b0);

    // Same block with CRC bit 0 flipped
    mark();
    do_start(1'b0, 512);
    begin_block(1'b0);
    for (int i = 0; i < 512; i++) send_byte(1'b0, 8'hFF);
    tx_crc[0] = 16'h7FA0;
    send_crc_end(1'b0);
    tick(6);
    @(negedge ex_clk);
    check("t2_done", done_seen - dbase, 1);
    check_bytes("t2", base, 512);
    check("t2_flags", {crc_err, end_err, timeout, overrun}, 4'b1000);

    // Four-byte block 12 34 56 78
    tx_bytes.delete();
    tx_bytes.push_back(8'h12); tx_bytes.push_back(8'h34);
    tx_bytes.push_back(8'h56); tx_bytes.push_back(8'h78);
`ifdef SD_RX_WIDE_BUS_EN
    for (int pass = 0; pass < 2; pass++) begin
      mark();
      do_start(1'b1, 4);
      begin_block(1'b1);
      for (int i = 0; i < 4; i++) send_byte(1'b1, tx_bytes[i]);
      if (pass == 1) tx_crc[2][5] = ~tx_crc[2][5];
      send_crc_end(1'b1);
      tick(4);
      @(negedge ex_clk);
      check("t3_done", done_seen - dbase, 1);
      check_bytes("t3", base, 4);
      check("t3_flags", {crc_err, end_err, timeout, overrun}, (pass == 1) ? 4'b1000 : 4'b0000);
    end
`else
    mark();
    do_start(1'b1, 4);
    begin_block(1'b0);
    for (int i = 0; i < 4; i++) send_byte(1'b0, tx_bytes[i]);
    send_crc_end(1'b0);
    tick(4);
    @(negedge ex_clk);
    check("t3_done", done_seen - dbase, 1);
    check_bytes("t3", base, 4);
    check("t3_flags", {crc_err, end_err, timeout, overrun}, 4'b0000);
`endif

    // Timeout after 16 idle samples
    mark();
    do_start(1'b0, 4);
    repeat (15) sd_sample(4'hF);
    @(negedge ex_clk);
    check("t4_pre_state", {busy, timeout}, 2'b10);
    check("t4_pre_done", done_seen - dbase, 0);
    sd_sample(4'hF);
    tick(2);
    @(negedge ex_clk);
    check("t4_done", done_seen - dbase, 1);
    check("t4_flags", {busy, rd_valid, crc_err, end_err, timeout, overrun}, 6'b000010);

    // Overrun: 10 bytes into an 8-deep FIFO with no consumer
    rd_ready = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 10; i++) tx_bytes.push_back(8'hA0 + 8'(i));
    mark();
    do_start(1'b0, 10);
    begin_block(1'b0);
    for (int i = 0; i < 10; i++) send_byte(1'b0, tx_bytes[i]);
    send_crc_end(1'b0);
    tick(4);
    @(negedge ex_clk);
    check("t5_done", done_seen - dbase, 1);
    check("t5_flags", {rd_valid, crc_err, end_err, timeout, overrun}, 5'b10001);
    check("t5_head", rd_data, 8'hA0);
    @(posedge ex_clk); #2;
    rd_ready = 1'b1;
    tick(20);
    check_bytes("t5", base, 8);
    check("t5_empty", rd_valid, 1'b0);

    // Abort in DATA after three bytes, then a good block
    tx_bytes.delete();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'h3C ^ 8'(i * 17));
    mark();
    do_start(1'b0, 8);
    begin_block(1'b0);
    for (int i = 0; i < 3; i++) send_byte(1'b0, tx_bytes[i]);
    abort = 1'b1;
    @(posedge ex_clk); #2;
    abort = 1'b0;
    @(negedge ex_clk);
    check("t6_busy", busy, 1'b0);
    tick(4);
    check("t6_no_done", done_seen - dbase, 0);
    check_bytes("t6", base, 3);
    tx_bytes.delete();
    tx_bytes.push_back(8'hC3); tx_bytes.push_back(8'h5A);
    mark();
    do_start(1'b0, 2);
    begin_block(1'b0);
    for (int i = 0; i < 2; i++) send_byte(1'b0, tx_bytes[i]);
    send_crc_end(1'b0);
    tick(4);
    @(negedge ex_clk);
    check("t6b_done", done_seen - dbase, 1);
    check_bytes("t6b", base, 2);
    check("t6b_flags", {crc_err, end_err, timeout, overrun}, 4'b0000);

    // Invalid block lengths finish at once with end_err only
    mark();
    do_start(1'b0, 0);
    tick(3);
    @(negedge ex_clk);
    check("t7_len0_done", done_seen - dbase, 1);
    check("t7_len0_flags", {busy, rd_valid, crc_err, end_err, timeout, overrun}, 6'b000100);
    mark();
    do_start(1'b0, 513);
    tick(3);
    @(negedge ex_clk);
    check("t7_len513_done", done_seen - dbase, 1);
    check("t7_len513_flags", {busy, rd_valid, crc_err, end_err, timeout, overrun}, 6'b000100);
    check("t7_no_bytes", got_q.size() - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
